// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_pipe
//  Purpose  : MEM/WB pipeline stage carrying up to LANES register-file write
//             requests per instruction. Valid/ready handshake with an
//             optional two-entry skid buffer, synchronous flush, per-lane
//             write squashing and an occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int SKID   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_wdata,
    input  logic [LANES*ADDR_W-1:0]   in_wd,
    input  logic [LANES-1:0]          in_wreg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_wdata,
    output logic [LANES*ADDR_W-1:0]   out_wd,
    output logic [LANES-1:0]          out_wreg,
    output logic [1:0]                count
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_half  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [LANES*DATA_W-1:0] r_main_wdata;
    logic [LANES*ADDR_W-1:0] r_main_wd;
    logic [LANES-1:0]        r_main_wreg;
    logic [LANES*DATA_W-1:0] r_skid_wdata;
    logic [LANES*ADDR_W-1:0] r_skid_wd;
    logic [LANES-1:0]        r_skid_wreg;
    logic [LANES-1:0]        w_in_wreg_sq;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic                    w_load_main;
    logic                    w_load_skid;
    logic                    w_skid_to_main;

    assign out_valid  = (r_state != c_st_empty);
    assign out_wdata  = r_main_wdata;
    assign out_wd     = r_main_wd;
    assign out_wreg   = r_main_wreg & {LANES{out_valid}};
    assign count      = r_state;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Squash writes to the zero register and all but the highest-index lane
    // among lanes targeting the same register.
    always_comb begin
        w_in_wreg_sq = '0;
        for (int i = 0; i < LANES; i++) begin
            w_in_wreg_sq[i] = in_wreg[i] && (in_wd[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (in_wreg[i] && in_wreg[j] &&
                    (in_wd[i*ADDR_W +: ADDR_W] == in_wd[j*ADDR_W +: ADDR_W]))
                    w_in_wreg_sq[i] = 1'b0;
            end
        end
    end

    // Next-state and register-load decisions; flush overrides normal flow.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_nxt = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in_xfer) begin
                        w_load_main = 1'b1;
                        w_state_nxt = c_st_half;
                    end
                end
                c_st_half: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_in_xfer) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = c_st_full;
                    end else if (w_out_xfer) begin
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_out_xfer) begin
                        w_skid_to_main = 1'b1;
                        w_state_nxt    = c_st_half;
                    end
                end
                default: w_state_nxt = c_st_empty;
            endcase
        end
    end

    // State and entry storage; data is kept on drain, only wreg is gated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_empty;
            r_main_wdata <= '0;
            r_main_wd    <= '0;
            r_main_wreg  <= '0;
            r_skid_wdata <= '0;
            r_skid_wd    <= '0;
            r_skid_wreg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main_wdata <= in_wdata;
                r_main_wd    <= in_wd;
                r_main_wreg  <= w_in_wreg_sq;
            end else if (w_skid_to_main) begin
                r_main_wdata <= r_skid_wdata;
                r_main_wd    <= r_skid_wd;
                r_main_wreg  <= r_skid_wreg;
            end
            if (w_load_skid) begin
                r_skid_wdata <= in_wdata;
                r_skid_wd    <= in_wd;
                r_skid_wreg  <= w_in_wreg_sq;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic r_in_ready;
            // Registered ready: low only when the next state is FULL (or in reset).
            always_ff @(posedge clk) begin
                if (rst) r_in_ready <= 1'b0;
                else     r_in_ready <= (w_state_nxt != c_st_full);
            end
            assign in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_pipe
//  Purpose  : Directed self-checking bench for mem_wb_pipe. One instance with
//             LANES=2/SKID=1, one with LANES=1/SKID=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Skid instance, two lanes
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [63:0] s_in_wdata, s_out_wdata;
    logic [9:0]  s_in_wd, s_out_wd;
    logic [1:0]  s_in_wreg, s_out_wreg, s_count;

    // Non-skid instance, one lane
    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_wdata, n_out_wdata;
    logic [4:0]  n_in_wd, n_out_wd;
    logic [0:0]  n_in_wreg, n_out_wreg;
    logic [1:0]  n_count;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_wdata(s_in_wdata), .in_wd(s_in_wd), .in_wreg(s_in_wreg),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_wdata(s_out_wdata), .out_wd(s_out_wd), .out_wreg(s_out_wreg),
        .count(s_count)
    );

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(1), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_wdata(n_in_wdata), .in_wd(n_in_wd), .in_wreg(n_in_wreg),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_wdata(n_out_wdata), .out_wd(n_out_wd), .out_wreg(n_out_wreg),
        .count(n_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive lane 0 of the skid instance; lane 1 idle.
    task automatic s_drive1(input logic v, input logic [4:0] wd, input logic [31:0] d);
        s_in_valid = v;
        s_in_wd    = {5'd0, wd};
        s_in_wdata = {32'd0, d};
        s_in_wreg  = 2'b01;
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 1'b0; s_out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_wd = {5'd0, 5'd5}; s_in_wdata = 64'h55; s_in_wreg = 2'b01;
        n_flush = 1'b0; n_out_ready = 1'b1;
        n_in_valid = 1'b1; n_in_wd = 5'd5; n_in_wdata = 32'h55; n_in_wreg = 1'b1;

        // Reset held two cycles with a pending input
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_s_out_valid", {63'd0, s_out_valid}, 64'd0);
            chk("rst_s_out_wreg", {62'd0, s_out_wreg}, 64'd0);
            chk("rst_s_count", {62'd0, s_count}, 64'd0);
            chk("rst_s_in_ready", {63'd0, s_in_ready}, 64'd0);
            chk("rst_n_out_valid", {63'd0, n_out_valid}, 64'd0);
            chk("rst_n_count", {62'd0, n_count}, 64'd0);
        end
        chk("rst_s_out_wdata", s_out_wdata, 64'd0);
        chk("rst_s_out_wd", {54'd0, s_out_wd}, 64'd0);
        rst = 1'b0;
        s_in_valid = 1'b0;
        n_in_valid = 1'b0;
        step();
        chk("post_rst_s_in_ready", {63'd0, s_in_ready}, 64'd1);
        chk("post_rst_s_out_valid", {63'd0, s_out_valid}, 64'd0);
        chk("post_rst_n_out_valid", {63'd0, n_out_valid}, 64'd0);

        // Streaming wd=1..8, data 0x10..0x80, one per cycle
        for (int k = 1; k <= 8; k++) begin
            s_drive1(1'b1, 5'(k), 32'(k * 16));
            step();
            chk("stream_valid", {63'd0, s_out_valid}, 64'd1);
            chk("stream_wd", {54'd0, s_out_wd}, 64'(k));
            chk("stream_wdata", s_out_wdata, 64'(k * 16));
            chk("stream_wreg", {62'd0, s_out_wreg}, 64'd1);
            chk("stream_count", {62'd0, s_count}, 64'd1);
            chk("stream_in_ready", {63'd0, s_in_ready}, 64'd1);
        end
        s_in_valid = 1'b0;
        step();
        chk("stream_drain_valid", {63'd0, s_out_valid}, 64'd0);
        chk("stream_drain_count", {62'd0, s_count}, 64'd0);
        chk("stream_drain_wreg", {62'd0, s_out_wreg}, 64'd0);

        // Backpressure: A then B with out_ready low from A's arrival
        s_drive1(1'b1, 5'd3, 32'hAAAA);
        step();
        chk("bp_count_a", {62'd0, s_count}, 64'd1);
        chk("bp_wd_a", {54'd0, s_out_wd}, 64'd3);
        s_out_ready = 1'b0;
        s_drive1(1'b1, 5'd4, 32'hBBBB);
        step();
        chk("bp_count_full", {62'd0, s_count}, 64'd2);
        chk("bp_in_ready_full", {63'd0, s_in_ready}, 64'd0);
        chk("bp_hold_a", s_out_wdata, 64'hAAAA);
        s_drive1(1'b1, 5'd9, 32'h9999);
        step();
        chk("bp_still_full", {62'd0, s_count}, 64'd2);
        chk("bp_still_a", {54'd0, s_out_wd}, 64'd3);
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        step();
        chk("bp_b_count", {62'd0, s_count}, 64'd1);
        chk("bp_b_wd", {54'd0, s_out_wd}, 64'd4);
        chk("bp_b_wdata", s_out_wdata, 64'hBBBB);
        chk("bp_b_in_ready", {63'd0, s_in_ready}, 64'd1);
        step();
        chk("bp_empty_count", {62'd0, s_count}, 64'd0);
        chk("bp_empty_valid", {63'd0, s_out_valid}, 64'd0);

        // Squash: same address on both lanes -> only lane 1 writes
        s_in_valid = 1'b1; s_in_wd = {5'd7, 5'd7}; s_in_wreg = 2'b11; s_in_wdata = 64'h2222_0000_1111;
        step();
        chk("sq_same_addr", {62'd0, s_out_wreg}, 64'h2);
        // Zero register on lane 0
        s_in_wd = {5'd6, 5'd0}; s_in_wreg = 2'b11;
        step();
        chk("sq_zero_reg", {62'd0, s_out_wreg}, 64'h2);
        // Distinct nonzero addresses both write
        s_in_wd = {5'd4, 5'd3}; s_in_wreg = 2'b11;
        step();
        chk("sq_distinct", {62'd0, s_out_wreg}, 64'h3);
        // Matching addresses but lane 1 disabled -> lane 0 keeps its write
        s_in_wd = {5'd9, 5'd9}; s_in_wreg = 2'b01;
        step();
        chk("sq_lane1_off", {62'd0, s_out_wreg}, 64'h1);
        s_in_valid = 1'b0;
        step();

        // Flush in FULL with a same-cycle input
        s_out_ready = 1'b0;
        s_drive1(1'b1, 5'd11, 32'hB0B0);
        step();
        s_drive1(1'b1, 5'd12, 32'hC0C0);
        step();
        chk("fl_pre_count", {62'd0, s_count}, 64'd2);
        s_flush = 1'b1;
        s_drive1(1'b1, 5'd13, 32'hD0D0);
        step();
        chk("fl_valid", {63'd0, s_out_valid}, 64'd0);
        chk("fl_count", {62'd0, s_count}, 64'd0);
        chk("fl_wreg", {62'd0, s_out_wreg}, 64'd0);
        s_flush = 1'b0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        step();
        chk("fl_after_valid", {63'd0, s_out_valid}, 64'd0);
        chk("fl_after_wreg", {62'd0, s_out_wreg}, 64'd0);
        chk("fl_after_in_ready", {63'd0, s_in_ready}, 64'd1);
        // Flush from HALF with an accepted input: input is discarded
        s_drive1(1'b1, 5'd14, 32'hE0E0);
        step();
        s_flush = 1'b1;
        s_drive1(1'b1, 5'd15, 32'hF0F0);
        step();
        chk("fl_half_valid", {63'd0, s_out_valid}, 64'd0);
        chk("fl_half_count", {62'd0, s_count}, 64'd0);
        s_flush = 1'b0;
        s_in_valid = 1'b0;

        // SKID=0: combinational ready
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_wd = 5'd2; n_in_wdata = 32'h22; n_in_wreg = 1'b1;
        step();
        chk("ns_valid", {63'd0, n_out_valid}, 64'd1);
        chk("ns_wd", {59'd0, n_out_wd}, 64'd2);
        chk("ns_in_ready_low", {63'd0, n_in_ready}, 64'd0);
        chk("ns_count", {62'd0, n_count}, 64'd1);
        n_in_wd = 5'd3; n_in_wdata = 32'h33;
        step();
        chk("ns_hold_wd", {59'd0, n_out_wd}, 64'd2);
        n_out_ready = 1'b1;
        #1;
        chk("ns_in_ready_comb", {63'd0, n_in_ready}, 64'd1);
        step();
        chk("ns_new_wd", {59'd0, n_out_wd}, 64'd3);
        chk("ns_new_wdata", {32'd0, n_out_wdata}, 64'h33);
        chk("ns_new_count", {62'd0, n_count}, 64'd1);
        chk("ns_new_wreg", {63'd0, n_out_wreg}, 64'd1);
        n_in_valid = 1'b0;
        step();
        chk("ns_drain_valid", {63'd0, n_out_valid}, 64'd0);
        chk("ns_drain_count", {62'd0, n_count}, 64'd0);
        chk("ns_drain_ready", {63'd0, n_in_ready}, 64'd1);

        // Reset mid-operation with two held entries
        s_out_ready = 1'b0;
        s_drive1(1'b1, 5'd20, 32'h2020);
        step();
        s_drive1(1'b1, 5'd21, 32'h2121);
        step();
        chk("rmid_pre_count", {62'd0, s_count}, 64'd2);
        rst = 1'b1;
        s_in_valid = 1'b0;
        step();
        chk("rmid_valid", {63'd0, s_out_valid}, 64'd0);
        chk("rmid_count", {62'd0, s_count}, 64'd0);
        rst = 1'b0;
        s_out_ready = 1'b1;
        step();
        chk("rmid_after_wreg", {62'd0, s_out_wreg}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
